decode_issue: RTL and testbench

Decoupled decode/issue stage: buffers fetched MIPS instructions in a DEPTH-entry queue, decodes the head entry's register usage, and issues it to execute under a valid/ready handshake only when a scoreboard shows no outstanding hazard. It sits between fetch and execute.

- Pending load destinations and in-flight HI/LO producers (multiply/divide) are tracked until writeback reports completion.
- A flush input empties the queue on redirect.

---
 rtl/decode_issue_if.sv | 41 ++++
 rtl/decode_issue.sv | 242 ++++++++++++++++++++++++
 tb/tb_decode_issue.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Fetch-to-issue and issue-to-execute signal bundle for the decode/issue stage.
// The slave modport is the decode_issue block; the master modport is whatever
// drives fetch, execute and writeback around it.
interface decode_issue_if #(
    parameter int PC_W = 32
);
    // fetch side
    logic            in_valid;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            in_ready;
    logic            flush;
    // execute side
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      out_waddr;
    logic [5:0]      out_raddr1;
    logic [5:0]      out_raddr2;
    logic            out_load;
    logic            out_store;
    logic            out_muldiv;
    // completion reports
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic            hilo_done;
    logic            stall;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_addr, hilo_done,
        input  in_ready, out_valid, out_instr, out_pc, out_waddr, out_raddr1, out_raddr2,
               out_load, out_store, out_muldiv, stall
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_addr, hilo_done,
        output in_ready, out_valid, out_instr, out_pc, out_waddr, out_raddr1, out_raddr2,
               out_load, out_store, out_muldiv, stall
    );
endinterface

// File: rtl/decode_issue.sv
// Decoupled decode/issue stage. Fetched MIPS instructions sit in a small
// circular queue; the head is decoded combinationally and handed to execute
// only when the scoreboard (pending load destinations, in-flight HI/LO
// producer) shows no hazard against it.
module decode_issue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_issue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // queue storage and bookkeeping
    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;

    // scoreboard
    logic [31:1]     busy_reg;
    logic            hilo_busy_reg;
    logic [31:0]     busy_full;

    logic            not_empty;
    logic            push;
    logic            pop;
    logic            hazard;
    logic            issue_valid;

    logic [31:0]     head_instr;
    logic [PC_W-1:0] head_pc;

    // decode results
    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic            use_rs;
    logic            use_rt;
    logic            dst_vld;
    logic [4:0]      dst;
    logic            dec_load;
    logic            dec_store;
    logic            dec_muldiv;
    logic            dec_hilo;
    logic [5:0]      dec_waddr;
    logic [5:0]      dec_raddr1;
    logic [5:0]      dec_raddr2;

    assign not_empty  = (count_reg != '0);
    assign bus.in_ready = (count_reg < FULL_COUNT);
    assign push       = bus.in_valid & bus.in_ready & ~bus.flush;

    // Empty queue presents all-zero payload so nothing stale leaks out.
    assign head_instr = not_empty ? instr_mem[rd_ptr_reg] : '0;
    assign head_pc    = not_empty ? pc_mem[rd_ptr_reg]    : '0;

    assign op    = head_instr[31:26];
    assign funct = head_instr[5:0];
    assign rs    = head_instr[25:21];
    assign rt    = head_instr[20:16];
    assign rd    = head_instr[15:11];

    // Classify the head instruction into register reads, destination and class flags.
    always_comb begin
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        dst_vld    = 1'b0;
        dst        = '0;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_muldiv = 1'b0;
        dec_hilo   = 1'b0;
        if (not_empty) begin
            casez (op)
                6'b000000: begin
                    casez (funct)
                        6'b0000?0, 6'b000011: begin   // SLL/SRL/SRA
                            use_rt  = 1'b1;
                            dst_vld = 1'b1;
                            dst     = rd;
                        end
                        6'b0100?0: begin              // MFHI/MFLO
                            dst_vld  = 1'b1;
                            dst      = rd;
                            dec_hilo = 1'b1;
                        end
                        6'b0100?1: begin              // MTHI/MTLO
                            use_rs   = 1'b1;
                            dec_hilo = 1'b1;
                        end
                        6'b0110??: begin              // MULT/MULTU/DIV/DIVU
                            use_rs     = 1'b1;
                            use_rt     = 1'b1;
                            dec_muldiv = 1'b1;
                            dec_hilo   = 1'b1;
                        end
                        6'b001000: begin              // JR
                            use_rs = 1'b1;
                        end
                        6'b001001: begin              // JALR
                            use_rs  = 1'b1;
                            dst_vld = 1'b1;
                            dst     = rd;
                        end
                        6'b00110?: begin              // SYSCALL/BREAK
                        end
                        default: begin                // three-register ALU ops
                            use_rs  = 1'b1;
                            use_rt  = 1'b1;
                            dst_vld = 1'b1;
                            dst     = rd;
                        end
                    endcase
                end
                6'b00010?: begin                      // BEQ/BNE
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
                6'b00011?, 6'b000001: begin           // BLEZ/BGTZ, REGIMM
                    use_rs = 1'b1;
                end
                6'b000010: begin                      // J
                end
                6'b000011: begin                      // JAL links into r31
                    dst_vld = 1'b1;
                    dst     = 5'd31;
                end
                6'b001111: begin                      // LUI
                    dst_vld = 1'b1;
                    dst     = rt;
                end
                6'b0010??, 6'b00110?, 6'b001110: begin // immediate ALU ops
                    use_rs  = 1'b1;
                    dst_vld = 1'b1;
                    dst     = rt;
                end
                6'b100???: begin                      // loads
                    use_rs   = 1'b1;
                    dst_vld  = 1'b1;
                    dst      = rt;
                    dec_load = 1'b1;
                end
                6'b101???: begin                      // stores
                    use_rs    = 1'b1;
                    use_rt    = 1'b1;
                    dec_store = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // r0 is never a real destination; absent operands read as address 0.
    assign dec_waddr  = (dst_vld && dst != 5'd0) ? {1'b1, dst} : 6'd0;
    assign dec_raddr1 = use_rs ? {1'b1, rs} : 6'd0;
    assign dec_raddr2 = use_rt ? {1'b1, rt} : 6'd0;

    // Hazards look only at registered scoreboard state: no same-cycle bypass.
    assign busy_full = {busy_reg, 1'b0};
    assign hazard = (dec_raddr1[5] & busy_full[dec_raddr1[4:0]])
                  | (dec_raddr2[5] & busy_full[dec_raddr2[4:0]])
                  | (dec_waddr[5]  & busy_full[dec_waddr[4:0]])
                  | (dec_hilo & hilo_busy_reg);

    assign issue_valid = not_empty & ~hazard & ~bus.flush;
    assign pop         = issue_valid & bus.out_ready;

    assign bus.out_valid  = issue_valid;
    assign bus.stall      = not_empty & hazard;
    assign bus.out_instr  = head_instr;
    assign bus.out_pc     = head_pc;
    assign bus.out_waddr  = dec_waddr;
    assign bus.out_raddr1 = dec_raddr1;
    assign bus.out_raddr2 = dec_raddr2;
    assign bus.out_load   = dec_load;
    assign bus.out_store  = dec_store;
    assign bus.out_muldiv = dec_muldiv;

    // Queue payload write; storage needs no reset since empty slots are never read out.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= bus.in_instr;
            pc_mem[wr_ptr_reg]    <= bus.in_pc;
        end
    end

    // Pointer and occupancy update; flush empties the queue and drops any push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (bus.flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

    // One busy bit per architectural register; issuing a load sets it, writeback clears it, set wins.
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_reg[gi] <= 1'b0;
            end else if (pop && dec_load && dec_waddr[5] && dec_waddr[4:0] == 5'(gi)) begin
                busy_reg[gi] <= 1'b1;
            end else if (bus.wb_valid && bus.wb_addr == 5'(gi)) begin
                busy_reg[gi] <= 1'b0;
            end
        end
    end

    // HI/LO in-flight flag; a new mult/div issue overrides a same-cycle completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hilo_busy_reg <= 1'b0;
        end else if (pop && dec_muldiv) begin
            hilo_busy_reg <= 1'b1;
        end else if (bus.hilo_done) begin
            hilo_busy_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: decode table, hand-written hazard/flush/wrap
// sequences, then randomized traffic against a queue-plus-scoreboard model.
module tb_decode_issue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk;
    logic rst_n;

    decode_issue_if #(.PC_W(PC_W)) bus ();

    decode_issue #(.DEPTH(DEPTH), .PC_W(PC_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference decode ----------------
    typedef struct {
        logic [5:0] w;
        logic [5:0] r1;
        logic [5:0] r2;
        logic       ld;
        logic       st;
        logic       md;
        logic       hl;
    } ref_dec_t;

    function automatic ref_dec_t ref_decode(input logic [31:0] ins);
        ref_dec_t d;
        int op, fn, rs, rt, rd, dst;
        bit urs, urt;
        op = int'(ins[31:26]); fn = int'(ins[5:0]);
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        dst = -1; urs = 0; urt = 0;
        d.ld = 0; d.st = 0; d.md = 0; d.hl = 0;
        if (op == 0) begin
            if (fn == 0 || fn == 2 || fn == 3) begin urt = 1; dst = rd; end
            else if (fn == 16 || fn == 18) begin dst = rd; d.hl = 1; end
            else if (fn == 17 || fn == 19) begin urs = 1; d.hl = 1; end
            else if (fn >= 24 && fn <= 27) begin urs = 1; urt = 1; d.md = 1; d.hl = 1; end
            else if (fn == 8) urs = 1;
            else if (fn == 9) begin urs = 1; dst = rd; end
            else if (fn == 12 || fn == 13) begin end
            else begin urs = 1; urt = 1; dst = rd; end
        end
        else if (op == 4 || op == 5) begin urs = 1; urt = 1; end
        else if (op == 1 || op == 6 || op == 7) urs = 1;
        else if (op == 2) begin end
        else if (op == 3) dst = 31;
        else if (op == 15) dst = rt;
        else if (op >= 8 && op <= 14) begin urs = 1; dst = rt; end
        else if (op >= 32 && op <= 39) begin urs = 1; dst = rt; d.ld = 1; end
        else if (op >= 40 && op <= 47) begin urs = 1; urt = 1; d.st = 1; end
        d.w  = (dst > 0) ? (6'd32 + 6'(dst)) : 6'd0;
        d.r1 = urs ? (6'd32 + 6'(rs)) : 6'd0;
        d.r2 = urt ? (6'd32 + 6'(rt)) : 6'd0;
        return d;
    endfunction

    // ---------------- random instruction source ----------------
    function automatic logic [31:0] gen_instr();
        logic [4:0]  a, b, c;
        logic [15:0] imm;
        int k;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        c = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        k = $urandom_range(0, 11);
        case (k)
            0:  return {6'h00, a, b, c, 5'd0, 6'h21};       // ADDU
            1:  return {6'h23, a, b, imm};                  // LW
            2:  return {6'h2b, a, b, imm};                  // SW
            3:  return {6'h00, a, b, 10'd0, 6'h18};         // MULT
            4:  return {6'h00, 10'd0, c, 5'd0, 6'h12};      // MFLO
            5:  return {6'h00, a, 15'd0, 6'h11};            // MTHI
            6:  return {6'h09, a, b, imm};                  // ADDIU
            7:  return {6'h0f, 5'd0, b, imm};               // LUI
            8:  return {6'h04, a, b, imm};                  // BEQ
            9:  return {6'h03, 10'd0, imm};                 // JAL
            10: return {6'h00, 5'd0, b, c, a, 6'h00};       // SLL
            default: return {6'h00, a, b, 10'd0, 6'h1b};    // DIVU
        endcase
    endfunction

    // ---------------- decode table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [5:0]  w;
        logic [5:0]  r1;
        logic [5:0]  r2;
        logic        ld;
        logic        st;
        logic        md;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t     mq [$];
    bit       busy_m [32];
    bit       hilo_m;

    initial begin
        vecs[0]  = '{32'h00221821, 6'h23, 6'h21, 6'h22, 1'b0, 1'b0, 1'b0}; // ADDU r3,r1,r2
        vecs[1]  = '{32'h8C250000, 6'h25, 6'h21, 6'h00, 1'b1, 1'b0, 1'b0}; // LW r5,0(r1)
        vecs[2]  = '{32'hAC250004, 6'h00, 6'h21, 6'h25, 1'b0, 1'b1, 1'b0}; // SW r5,4(r1)
        vecs[3]  = '{32'h00220018, 6'h00, 6'h21, 6'h22, 1'b0, 1'b0, 1'b1}; // MULT r1,r2
        vecs[4]  = '{32'h00002012, 6'h24, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0}; // MFLO r4
        vecs[5]  = '{32'h00E00011, 6'h00, 6'h27, 6'h00, 1'b0, 1'b0, 1'b0}; // MTHI r7
        vecs[6]  = '{32'h00031100, 6'h22, 6'h00, 6'h23, 1'b0, 1'b0, 1'b0}; // SLL r2,r3,4
        vecs[7]  = '{32'h03E00008, 6'h00, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0}; // JR r31
        vecs[8]  = '{32'h0080F809, 6'h3F, 6'h24, 6'h00, 1'b0, 1'b0, 1'b0}; // JALR r31,r4
        vecs[9]  = '{32'h0000000C, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0}; // SYSCALL
        vecs[10] = '{32'h10220003, 6'h00, 6'h21, 6'h22, 1'b0, 1'b0, 1'b0}; // BEQ r1,r2
        vecs[11] = '{32'h1CC00002, 6'h00, 6'h26, 6'h00, 1'b0, 1'b0, 1'b0}; // BGTZ r6
        vecs[12] = '{32'h05200005, 6'h00, 6'h29, 6'h00, 1'b0, 1'b0, 1'b0}; // BLTZ r9
        vecs[13] = '{32'h08000010, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0}; // J
        vecs[14] = '{32'h0C000010, 6'h3F, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0}; // JAL
        vecs[15] = '{32'h25280005, 6'h28, 6'h29, 6'h00, 1'b0, 1'b0, 1'b0}; // ADDIU r8,r9,5
        vecs[16] = '{32'h3C001234, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0}; // LUI r0
        vecs[17] = '{32'h3C0A1234, 6'h2A, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0}; // LUI r10
        vecs[18] = '{32'h00000000, 6'h00, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0}; // NOP
        vecs[19] = '{32'h40000000, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0}; // COP0 (unlisted)
        vecs[20] = '{32'h80400000, 6'h00, 6'h22, 6'h00, 1'b1, 1'b0, 1'b0}; // LB r0,0(r2)

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 1'b0;
        bus.out_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.hilo_done = 1'b0;

        // reset state
        #2;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_waddr", bus.out_waddr, 0);
        check("rst_out_raddr2", bus.out_raddr2, 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // decode table: push into empty queue, check head one edge later, then flush
        for (int i = 0; i < NVEC; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = vecs[i].instr; bus.in_pc = 32'(i * 4);
            cyc();
            bus.in_valid = 1'b0;
            #1;
            check("vec_out_valid", bus.out_valid, 1);
            check("vec_stall", bus.stall, 0);
            check("vec_instr", bus.out_instr, vecs[i].instr);
            check("vec_pc", bus.out_pc, 64'(i * 4));
            check("vec_waddr", bus.out_waddr, vecs[i].w);
            check("vec_raddr1", bus.out_raddr1, vecs[i].r1);
            check("vec_raddr2", bus.out_raddr2, vecs[i].r2);
            check("vec_flags", {bus.out_load, bus.out_store, bus.out_muldiv},
                  {vecs[i].ld, vecs[i].st, vecs[i].md});
            $display("vector %0d instr=%08h waddr=%02h raddr1=%02h raddr2=%02h",
                     i, bus.out_instr, bus.out_waddr, bus.out_raddr1, bus.out_raddr2);
            bus.flush = 1'b1;
            cyc();
            bus.flush = 1'b0;
            #1;
            check("vec_after_flush_valid", bus.out_valid, 0);
        end

        // load-use: LW r5 then ADDU r6,r5,r5
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h8C250000; bus.in_pc = 32'h100;
        cyc();
        bus.in_instr = 32'h00A53021; bus.in_pc = 32'h104;
        #1;
        check("lu_lw_valid", bus.out_valid, 1);
        check("lu_lw_instr", bus.out_instr, 32'h8C250000);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        check("lu_addu_stall", bus.stall, 1);
        check("lu_addu_blocked", bus.out_valid, 0);
        check("lu_head_instr", bus.out_instr, 32'h00A53021);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("lu_hold_stall", bus.stall, 1);
        end
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5;
        #1;
        check("lu_no_bypass", bus.stall, 1);
        cyc();
        bus.wb_valid = 1'b0;
        #1;
        check("lu_issue_valid", bus.out_valid, 1);
        check("lu_issue_stall", bus.stall, 0);
        check("lu_issue_instr", bus.out_instr, 32'h00A53021);
        $display("load-use issue pc=%08h instr=%08h", bus.out_pc, bus.out_instr);
        cyc();
        check("lu_empty", bus.out_valid, 0);

        // MULT r1,r2 then MFLO r4
        bus.in_valid = 1'b1; bus.in_instr = 32'h00220018; bus.in_pc = 32'h200;
        cyc();
        bus.in_instr = 32'h00002012; bus.in_pc = 32'h204;
        #1;
        check("md_mult_valid", bus.out_valid, 1);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        check("md_mflo_stall", bus.stall, 1);
        cyc();
        check("md_mflo_hold", bus.stall, 1);
        bus.hilo_done = 1'b1;
        #1;
        check("md_no_bypass", bus.out_valid, 0);
        cyc();
        bus.hilo_done = 1'b0;
        #1;
        check("md_mflo_valid", bus.out_valid, 1);
        check("md_mflo_waddr", bus.out_waddr, 6'h24);
        $display("muldiv issue pc=%08h instr=%08h", bus.out_pc, bus.out_instr);
        cyc();

        // fill/drain rounds with pointer wrap
        for (int r = 0; r < 3; r++) begin
            bus.out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                bus.in_valid = 1'b1;
                bus.in_instr = 32'h24000000 | (32'(8 + k) << 16) | 32'(r * 8 + k);
                bus.in_pc = 32'h300 + 32'(k * 4);
                #1;
                check("fill_in_ready", bus.in_ready, (k < DEPTH) ? 1 : 0);
                cyc();
            end
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                #1;
                check("drain_valid", bus.out_valid, 1);
                check("drain_instr", bus.out_instr,
                      32'h24000000 | (32'(8 + k) << 16) | 32'(r * 8 + k));
                $display("drain round %0d issue pc=%08h instr=%08h", r, bus.out_pc, bus.out_instr);
                cyc();
            end
            check("drain_empty", bus.out_valid, 0);
        end

        // flush keeps the scoreboard: LW r7 issues, 3 entries queued, flush
        bus.in_valid = 1'b1; bus.in_instr = 32'h8C270000; bus.in_pc = 32'h400;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_instr = 32'h24000000 | 32'(k); bus.in_pc = 32'h404 + 32'(k * 4);
            cyc();
        end
        bus.flush = 1'b1;
        #1;
        check("fl_gate_valid", bus.out_valid, 0);
        cyc();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        check("fl_valid", bus.out_valid, 0);
        check("fl_stall", bus.stall, 0);
        check("fl_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h3C001234; bus.in_pc = 32'h500;
        cyc();
        bus.in_instr = 32'h00000000; bus.in_pc = 32'h504;
        #1;
        check("r0_lui_valid", bus.out_valid, 1);
        check("r0_lui_waddr", bus.out_waddr, 0);
        cyc();
        bus.in_instr = 32'h00E04021; bus.in_pc = 32'h508;
        #1;
        check("r0_nop_valid", bus.out_valid, 1);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        check("fl_busy_kept", bus.stall, 1);
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7;
        cyc();
        bus.wb_valid = 1'b0;
        #1;
        check("fl_wb_clears", bus.out_valid, 1);
        cyc();

        // asynchronous reset mid-operation
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h00221821; bus.in_pc = 32'h600;
        cyc();
        bus.in_valid = 1'b0;
        #1;
        check("ar_pre_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("ar_valid", bus.out_valid, 0);
        check("ar_instr", bus.out_instr, 0);
        check("ar_in_ready", bus.in_ready, 1);
        cyc();
        rst_n = 1'b1;

        // randomized traffic against the model
        mq.delete();
        for (int i = 0; i < 32; i++) busy_m[i] = 0;
        hilo_m = 0;
        for (int c = 0; c < 400; c++) begin
            ref_dec_t d;
            bit exp_rdy, haz, exp_vld, exp_stl, do_pop, do_push;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_instr  = gen_instr();
            bus.in_pc     = 32'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            bus.wb_valid  = ($urandom_range(0, 2) == 0);
            bus.wb_addr   = 5'($urandom_range(0, 7));
            bus.hilo_done = ($urandom_range(0, 3) == 0);
            #1;
            exp_rdy = (mq.size() < DEPTH);
            if (mq.size() > 0) d = ref_decode(mq[0].instr);
            else d = '{6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};
            haz = (mq.size() > 0) &&
                  ((d.r1 >= 32 && busy_m[d.r1 - 32]) ||
                   (d.r2 >= 32 && busy_m[d.r2 - 32]) ||
                   (d.w  >= 32 && busy_m[d.w - 32]) ||
                   (d.hl && hilo_m));
            exp_vld = (mq.size() > 0) && !haz && !bus.flush;
            exp_stl = (mq.size() > 0) && haz;
            check("rnd_in_ready", bus.in_ready, exp_rdy);
            check("rnd_out_valid", bus.out_valid, exp_vld);
            check("rnd_stall", bus.stall, exp_stl);
            if (mq.size() > 0) begin
                check("rnd_instr", bus.out_instr, mq[0].instr);
                check("rnd_pc", bus.out_pc, mq[0].pc);
                check("rnd_waddr", bus.out_waddr, d.w);
                check("rnd_raddr1", bus.out_raddr1, d.r1);
                check("rnd_raddr2", bus.out_raddr2, d.r2);
                check("rnd_flags", {bus.out_load, bus.out_store, bus.out_muldiv}, {d.ld, d.st, d.md});
            end
            @(posedge clk);
            do_pop  = exp_vld && bus.out_ready;
            do_push = bus.in_valid && exp_rdy && !bus.flush;
            if (do_pop) begin
                $display("random issue pc=%08h instr=%08h", mq[0].pc, mq[0].instr);
                void'(mq.pop_front());
            end
            if (bus.flush) mq.delete();
            else if (do_push) mq.push_back('{bus.in_instr, bus.in_pc});
            if (bus.wb_valid) busy_m[bus.wb_addr] = 0;
            if (bus.hilo_done) hilo_m = 0;
            if (do_pop && d.ld && d.w >= 32) busy_m[d.w - 32] = 1;
            if (do_pop && d.md) hilo_m = 1;
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
